// File: rtl/addsub_result_stage_if.sv
// Handshake bundle between execute, the add/sub result stage and writeback/bypass.
// slave: the result stage's view. master: the surrounding execute/writeback view.
interface addsub_result_stage_if #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned REGW  = 5
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_result;
    logic             in_result_slt;
    logic             in_is_slt;
    logic [REGW-1:0]  in_dst;

    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [REGW-1:0]  out_dst;
    logic             out_we;

    logic             fwd_valid;
    logic [REGW-1:0]  fwd_dst;
    logic [WIDTH-1:0] fwd_data;

    modport slave (
        input  in_valid, in_result, in_result_slt, in_is_slt, in_dst, out_ready,
        output in_ready, out_valid, out_data, out_dst, out_we,
        output fwd_valid, fwd_dst, fwd_data
    );

    modport master (
        output in_valid, in_result, in_result_slt, in_is_slt, in_dst, out_ready,
        input  in_ready, out_valid, out_data, out_dst, out_we,
        input  fwd_valid, fwd_dst, fwd_data
    );
endinterface

// File: rtl/addsub_result_stage.sv
// Result register stage after the add/sub/compare unit: forms the final ALU word,
// tags it with its destination, and hands it to writeback through a 2-entry
// (head + skid) buffer whose in_ready is registered.
// Optional performance counters: define ADDSUB_RESULT_STAGE_PERF_EN.
module addsub_result_stage #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned REGW  = 5
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     squash,
    addsub_result_stage_if.slave     bus
`ifdef ADDSUB_RESULT_STAGE_PERF_EN
    ,
    output logic [31:0]              perf_stall_cycles,
    output logic [31:0]              perf_slt_count
`endif
);

    localparam int unsigned PERF_W = 32;

    // Head (presented to writeback) and skid entries
    logic             head_valid, head_valid_n;
    logic [WIDTH-1:0] head_data,  head_data_n;
    logic [REGW-1:0]  head_dst,   head_dst_n;
    logic             head_we,    head_we_n;
    logic             skid_valid, skid_valid_n;
    logic [WIDTH-1:0] skid_data,  skid_data_n;
    logic [REGW-1:0]  skid_dst,   skid_dst_n;
    logic             in_ready_q, in_ready_n;

    logic             accept_c;
    logic             head_load_c;
    logic [WIDTH-1:0] in_word_c;

    // Word formation: compare ops produce a zero-extended flag, others pass the sum
    assign in_word_c   = bus.in_is_slt ? WIDTH'(bus.in_result_slt) : bus.in_result;
    assign accept_c    = bus.in_valid & in_ready_q & ~squash;
    assign head_load_c = ~head_valid | bus.out_ready;

    // Next-state for head/skid entries; squash outranks everything else
    always_comb begin
        head_valid_n = head_valid;
        head_data_n  = head_data;
        head_dst_n   = head_dst;
        head_we_n    = head_we;
        skid_valid_n = skid_valid;
        skid_data_n  = skid_data;
        skid_dst_n   = skid_dst;

        if (squash) begin
            head_valid_n = 1'b0;
            head_we_n    = 1'b0;
            skid_valid_n = 1'b0;
        end else if (head_load_c) begin
            if (skid_valid) begin
                head_valid_n = 1'b1;
                head_data_n  = skid_data;
                head_dst_n   = skid_dst;
                head_we_n    = (skid_dst != '0);
                skid_valid_n = accept_c;
                if (accept_c) begin
                    skid_data_n = in_word_c;
                    skid_dst_n  = bus.in_dst;
                end
            end else if (accept_c) begin
                head_valid_n = 1'b1;
                head_data_n  = in_word_c;
                head_dst_n   = bus.in_dst;
                head_we_n    = (bus.in_dst != '0);
            end else begin
                head_valid_n = 1'b0;
                head_we_n    = 1'b0;
            end
        end else if (accept_c) begin
            skid_valid_n = 1'b1;
            skid_data_n  = in_word_c;
            skid_dst_n   = bus.in_dst;
        end

        in_ready_n = ~skid_valid_n;
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            head_valid <= 1'b0;
            head_data  <= '0;
            head_dst   <= '0;
            head_we    <= 1'b0;
            skid_valid <= 1'b0;
            skid_data  <= '0;
            skid_dst   <= '0;
            in_ready_q <= 1'b1;
        end else begin
            head_valid <= head_valid_n;
            head_data  <= head_data_n;
            head_dst   <= head_dst_n;
            head_we    <= head_we_n;
            skid_valid <= skid_valid_n;
            skid_data  <= skid_data_n;
            skid_dst   <= skid_dst_n;
            in_ready_q <= in_ready_n;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = head_valid;
    assign bus.out_data  = head_data;
    assign bus.out_dst   = head_dst;
    assign bus.out_we    = head_we;
    assign bus.fwd_valid = head_we;
    assign bus.fwd_dst   = head_dst;
    assign bus.fwd_data  = head_data;

`ifdef ADDSUB_RESULT_STAGE_PERF_EN
    logic [PERF_W-1:0] stall_q;
    logic [PERF_W-1:0] slt_q;

    // Stall and compare-op counters; wrap naturally, cleared only by reset
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_q <= '0;
            slt_q   <= '0;
        end else begin
            if (head_valid && !bus.out_ready) begin
                stall_q <= stall_q + PERF_W'(1);
            end
            if (accept_c && bus.in_is_slt) begin
                slt_q <= slt_q + PERF_W'(1);
            end
        end
    end

    assign perf_stall_cycles = stall_q;
    assign perf_slt_count    = slt_q;
`endif

endmodule

// File: tb/tb_addsub_result_stage.sv
// Bench for addsub_result_stage: directed scenarios plus random traffic checked
// against a queue-based reference model of the stage.
module tb_addsub_result_stage;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned REGW  = 5;

    typedef struct {
        logic [WIDTH-1:0] data;
        logic [REGW-1:0]  dst;
    } entry_t;

    logic clk;
    logic reset;
    logic squash;

    addsub_result_stage_if #(.WIDTH(WIDTH), .REGW(REGW)) bus ();

`ifdef ADDSUB_RESULT_STAGE_PERF_EN
    logic [31:0] perf_stall_cycles;
    logic [31:0] perf_slt_count;
`endif

    addsub_result_stage #(.WIDTH(WIDTH), .REGW(REGW)) dut (
        .clk               (clk),
        .reset             (reset),
        .squash            (squash),
        .bus               (bus)
`ifdef ADDSUB_RESULT_STAGE_PERF_EN
        ,
        .perf_stall_cycles (perf_stall_cycles),
        .perf_slt_count    (perf_slt_count)
`endif
    );

    always #5 clk = ~clk;

    // Reference model: ordered contents of the stage (capacity 2)
    entry_t      q[$];
    bit          m_rdy;
    int unsigned m_stall;
    int unsigned m_slt;

    int n_checks;
    int n_pass;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    endtask

    task automatic compare_all();
        check("in_ready", 32'(bus.in_ready), 32'(m_rdy));
        check("out_valid", 32'(bus.out_valid), 32'(q.size() > 0));
        if (q.size() > 0) begin
            check("out_data", bus.out_data, q[0].data);
            check("out_dst", 32'(bus.out_dst), 32'(q[0].dst));
            check("out_we", 32'(bus.out_we), 32'(q[0].dst != 0));
            check("fwd_valid", 32'(bus.fwd_valid), 32'(q[0].dst != 0));
            check("fwd_dst", 32'(bus.fwd_dst), 32'(q[0].dst));
            check("fwd_data", bus.fwd_data, q[0].data);
        end else begin
            check("out_we_idle", 32'(bus.out_we), 32'd0);
            check("fwd_valid_idle", 32'(bus.fwd_valid), 32'd0);
        end
`ifdef ADDSUB_RESULT_STAGE_PERF_EN
        check("perf_stall", perf_stall_cycles, m_stall);
        check("perf_slt", perf_slt_count, m_slt);
`endif
    endtask

    // One clock: advance the model on the edge, then compare on the falling edge
    task automatic tick();
        bit     acc;
        entry_t e;
        @(posedge clk);
        if (reset) begin
            q.delete();
            m_rdy   = 1'b1;
            m_stall = 0;
            m_slt   = 0;
        end else begin
            acc = bus.in_valid && m_rdy && !squash;
            if (q.size() > 0 && !bus.out_ready) m_stall++;
            if (acc && bus.in_is_slt) m_slt++;
            if (squash) begin
                q.delete();
            end else begin
                if (q.size() > 0 && bus.out_ready) void'(q.pop_front());
                if (acc) begin
                    e.data = bus.in_is_slt ? {31'd0, bus.in_result_slt} : bus.in_result;
                    e.dst  = bus.in_dst;
                    q.push_back(e);
                end
            end
            m_rdy = (q.size() < 2);
        end
        @(negedge clk);
        compare_all();
    endtask

    task automatic drive(input logic v, input logic [31:0] r, input logic s, input logic is, input logic [4:0] d);
        bus.in_valid      = v;
        bus.in_result     = r;
        bus.in_result_slt = s;
        bus.in_is_slt     = is;
        bus.in_dst        = d;
    endtask

    initial begin
        clk = 1'b0;
        n_checks = 0;
        n_pass   = 0;
        m_rdy    = 1'b1;
        m_stall  = 0;
        m_slt    = 0;
        reset    = 1'b1;
        squash   = 1'b0;
        bus.out_ready = 1'b0;
        drive(1'b0, 32'd0, 1'b0, 1'b0, 5'd0);

        // Reset state
        tick();
        tick();
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_data", bus.out_data, 32'd0);
        check("rst_out_dst", 32'(bus.out_dst), 32'd0);
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        reset = 1'b0;

        // Single beat
        bus.out_ready = 1'b1;
        drive(1'b1, 32'h0000_0005, 1'b0, 1'b0, 5'd3);
        tick();
        check("beat_valid", 32'(bus.out_valid), 32'd1);
        check("beat_data", bus.out_data, 32'd5);
        check("beat_dst", 32'(bus.out_dst), 32'd3);
        check("beat_we", 32'(bus.out_we), 32'd1);
        check("beat_fwd", 32'(bus.fwd_valid), 32'd1);

        // SLT select
        drive(1'b1, 32'hFFFF_FFFF, 1'b1, 1'b1, 5'd4);
        tick();
        check("slt_one", bus.out_data, 32'h0000_0001);
        drive(1'b1, 32'hFFFF_FFFF, 1'b0, 1'b1, 5'd4);
        tick();
        check("slt_zero", bus.out_data, 32'h0000_0000);
        drive(1'b0, 32'd0, 1'b0, 1'b0, 5'd0);
        tick();

        // Backpressure: A, B, C with writeback stalled
        bus.out_ready = 1'b0;
        drive(1'b1, 32'd1, 1'b0, 1'b0, 5'd1);
        tick();
        drive(1'b1, 32'd2, 1'b0, 1'b0, 5'd2);
        tick();
        check("bp_ready_low", 32'(bus.in_ready), 32'd0);
        drive(1'b1, 32'd3, 1'b0, 1'b0, 5'd3);
        tick();
        tick();
        check("bp_head_a", bus.out_data, 32'd1);
        check("bp_ready_held", 32'(bus.in_ready), 32'd0);
        bus.out_ready = 1'b1;
        tick();
        check("bp_out_b", bus.out_data, 32'd2);
        tick();
        check("bp_out_c", bus.out_data, 32'd3);
        drive(1'b0, 32'd0, 1'b0, 1'b0, 5'd0);
        tick();
        check("bp_drained", 32'(bus.out_valid), 32'd0);

        // r0 suppression
        drive(1'b1, 32'h0000_1234, 1'b0, 1'b0, 5'd0);
        tick();
        check("r0_valid", 32'(bus.out_valid), 32'd1);
        check("r0_data", bus.out_data, 32'h0000_1234);
        check("r0_we", 32'(bus.out_we), 32'd0);
        check("r0_fwd", 32'(bus.fwd_valid), 32'd0);
        drive(1'b0, 32'd0, 1'b0, 1'b0, 5'd0);
        tick();

        // Squash with both entries full and input pending
        bus.out_ready = 1'b0;
        drive(1'b1, 32'h0000_00A1, 1'b0, 1'b0, 5'd7);
        tick();
        drive(1'b1, 32'h0000_00A2, 1'b0, 1'b0, 5'd8);
        tick();
        drive(1'b1, 32'h0000_00A3, 1'b0, 1'b0, 5'd9);
        squash = 1'b1;
        tick();
        check("sq_valid", 32'(bus.out_valid), 32'd0);
        check("sq_ready", 32'(bus.in_ready), 32'd1);
        squash = 1'b0;
        bus.out_ready = 1'b1;
        drive(1'b0, 32'd0, 1'b0, 1'b0, 5'd0);
        tick();
        check("sq_no_ghost", 32'(bus.out_valid), 32'd0);

`ifdef ADDSUB_RESULT_STAGE_PERF_EN
        // Perf counters: 7 stall cycles and 2 compare accepts after a fresh reset
        reset = 1'b1;
        tick();
        check("perf_rst_stall", perf_stall_cycles, 32'd0);
        check("perf_rst_slt", perf_slt_count, 32'd0);
        reset = 1'b0;
        bus.out_ready = 1'b0;
        drive(1'b1, 32'd0, 1'b1, 1'b1, 5'd5);
        tick();
        tick();
        drive(1'b0, 32'd0, 1'b0, 1'b0, 5'd0);
        repeat (6) tick();
        check("perf_stall7", perf_stall_cycles, 32'd7);
        check("perf_slt2", perf_slt_count, 32'd2);
        bus.out_ready = 1'b1;
        tick();
        tick();
`endif

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            reset         = ($urandom_range(0, 149) == 0);
            squash        = ($urandom_range(0, 24) == 0);
            bus.out_ready = ($urandom_range(0, 2) != 0);
            drive(($urandom_range(0, 3) != 0), $urandom(), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)),
                  ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(1, 31)));
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/addsub_result_stage.md
Name: addsub_result_stage

Overview:
- Pipeline register stage directly downstream of the add/sub/compare unit.
- Takes the raw WIDTH-bit sum, the SLT/SLTU flag and the op's slt select; forms the final ALU word (sum or zero-extended compare bit); tags it with the destination register.
- Presents the word to writeback through a valid/ready handshake, with a 2-entry skid buffer so writeback stalls never create a combinational ready path back into execute.
- Exposes the head entry as a forwarding source for the operand bypass muxes.

Parameters:
WIDTH, 32, datapath width of result and out_data
REGW, 5, destination register index width

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
squash  input  1  flush; drops all held entries and same-cycle input
in_valid  input  1  upstream result present
in_ready  output  1  stage can accept; registered, depends only on skid occupancy
in_result  input  WIDTH  sum from add/sub unit
in_result_slt  input  1  compare bit (sum carry/sign) from add/sub unit
in_is_slt  input  1  op[2] of the add/sub opcode; selects compare result
in_dst  input  REGW  destination register index
out_valid  output  1  head entry valid
out_ready  input  1  writeback consumes head this cycle
out_data  output  WIDTH  final ALU word
out_dst  output  REGW  destination index
out_we  output  1  out_valid and out_dst != 0
fwd_valid  output  1  equals out_we
fwd_dst  output  REGW  equals out_dst
fwd_data  output  WIDTH  equals out_data

Behaviour:
- Word formation at capture: in_is_slt=1 -> {WIDTH-1 zeros, in_result_slt}; else in_result. No other arithmetic.
- Storage: head register (out_*) and skid register, each with a valid bit.
- Accept = in_valid & in_ready & ~squash.
- Head update each cycle, priority order:
  - squash: head_valid <= 0.
  - head empty or out_ready: head <= skid if skid valid, else accepted input if any, else head_valid <= 0.
  - otherwise: hold.
- Skid update:
  - squash: skid_valid <= 0.
  - accept while head valid and ~out_ready: skid <= input.
  - skid moving to head: skid_valid <= 0; if an input is accepted the same cycle it is written to skid.
- in_ready <= ~next skid_valid (registered). Never drops input: at most one beat in flight after in_ready falls, and skid holds it.
- Latency: 1 cycle, input to out_valid, when unstalled. Throughput: 1/cycle with out_ready held high.
- Ordering: strict FIFO; skid always drains before new input.
- out_dst == 0: entry travels normally but out_we = 0 and fwd_valid = 0 (r0 never written or forwarded).
- Data/dst registers load only when their valid is set, so they hold while stalled.
- out_*/fwd_* are driven directly from the head register; no combinational input-to-output path.
- Reset (sync, active-high): head_valid = 0, skid_valid = 0, out_data = 0, out_dst = 0, in_ready = 1, counters = 0.
- Reset mid-stall discards both entries.
- squash and reset outranks every other event, including a simultaneous out_ready or in_valid. After squash, in_ready = 1 on the next cycle.

Optional Feature:
ADDSUB_RESULT_STAGE_PERF_EN
- Defined: adds outputs perf_stall_cycles [31:0] and perf_slt_count [31:0].
  - perf_stall_cycles increments each cycle out_valid & ~out_ready.
  - perf_slt_count increments on each accept with in_is_slt=1.
  - Both wrap at 2^32, clear on reset only (not on squash).
- Undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset then single beat: in_result=32'h0000_0005, in_is_slt=0, in_dst=3, out_ready=1 -> next cycle out_valid=1, out_data=5, out_dst=3, out_we=1, fwd_valid=1.
- SLT select: in_result=32'hFFFF_FFFF, in_result_slt=1, in_is_slt=1 -> out_data=32'h0000_0001. With in_result_slt=0 -> out_data=0.
- Backpressure: stream A=1, B=2, C=3 back-to-back with out_ready=0 from cycle 1 -> head=A, skid=B, in_ready=0 from the cycle after B is captured, C held upstream. Raise out_ready -> outputs A, B, C in order, no loss or duplication.
- r0 suppression: in_dst=0, in_result=32'h1234 -> out_valid=1, out_data=32'h1234, out_we=0, fwd_valid=0.
- Squash with both entries full and in_valid=1 -> next cycle out_valid=0, in_ready=1; the squashed-cycle input never appears at the output.
- Perf (macro defined): hold out_ready=0 for 7 cycles with head valid, accept 2 SLT ops -> perf_stall_cycles=7, perf_slt_count=2. Both read 0 after reset.
